// File: rtl/_gcd_arbiter_if.sv
// Bundle of requester-side and engine-side signals for the two-client GCD arbiter.
// The slave modport is the arbiter's view; master is the requesters/engine side.
interface _gcd_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             _req0;
  logic             _req1;
  logic [WIDTH-1:0] _a0;
  logic [WIDTH-1:0] _b0;
  logic [WIDTH-1:0] _a1;
  logic [WIDTH-1:0] _b1;
  logic             _gnt0;
  logic             _gnt1;
  logic             _done0;
  logic             _done1;
  logic [WIDTH-1:0] _res0;
  logic [WIDTH-1:0] _res1;
  logic             _err0;
  logic             _err1;
  logic             _eng_start;
  logic [WIDTH-1:0] _eng_num0;
  logic [WIDTH-1:0] _eng_num1;
  logic             _eng_done;
  logic [WIDTH-1:0] _eng_result;
  logic             _busy;

  // Handshake: _reqN is a level request sampled only while the arbiter is
  // idle; _gntN pulses once when that request is accepted and _doneN pulses
  // once when its job completes. _eng_start pulses once per engine job and
  // _eng_done is honoured only while a job is waiting on the engine.
  modport slave (
    input  _req0, _req1, _a0, _b0, _a1, _b1, _eng_done, _eng_result,
    output _gnt0, _gnt1, _done0, _done1, _res0, _res1, _err0, _err1,
    output _eng_start, _eng_num0, _eng_num1, _busy
  );

  modport master (
    output _req0, _req1, _a0, _b0, _a1, _b1, _eng_done, _eng_result,
    input  _gnt0, _gnt1, _done0, _done1, _res0, _res1, _err0, _err1,
    input  _eng_start, _eng_num0, _eng_num1, _busy
  );
endinterface

// File: rtl/_gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine between two requesters.
// One job in flight; zero operands and engine timeouts are reported as errors.
module _gcd_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        _clock,
  input  logic        _reset,
  _gcd_arbiter_if.slave bus,
  output logic [1:0]  o_dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_owner;
  logic             r_last;
  logic [CW-1:0]    r_cnt;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_done0;
  logic             r_done1;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;
  logic             r_err0;
  logic             r_err1;
  logic             r_eng_start;
  logic [WIDTH-1:0] r_eng_num0;
  logic [WIDTH-1:0] r_eng_num1;
  logic             r_busy;

  logic             w_any_req;
  logic             w_pick;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_op_zero;
  logic [CW-1:0]    w_cnt_next;
  logic             w_timeout;
  logic             w_fin;
  logic [WIDTH-1:0] w_fin_res;
  logic             w_fin_err;

  // When both ask, the one not served last wins; r_last resets to 1 so 0 goes first.
  assign w_any_req  = bus._req0 | bus._req1;
  assign w_pick     = (bus._req0 & bus._req1) ? ~r_last : bus._req1;
  assign w_op_a     = w_pick ? bus._a1 : bus._a0;
  assign w_op_b     = w_pick ? bus._b1 : bus._b0;
  assign w_op_zero  = (w_op_a == '0) || (w_op_b == '0);
  assign w_cnt_next = r_cnt + CW'(1);
  assign w_timeout  = (w_cnt_next == TIMEOUT_C);

  // Job completion is decided one cycle early so _done/_res/_err are
  // registered and visible during the RESPOND cycle itself.
  always_comb begin
    w_fin     = 1'b0;
    w_fin_res = '0;
    w_fin_err = 1'b0;
    case (r_state)
      S_ISSUE: begin
        if ((r_eng_num0 == '0) || (r_eng_num1 == '0)) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus._eng_done) begin
          w_fin     = 1'b1;
          w_fin_res = bus._eng_result;
        end else if (w_timeout) begin
          w_fin     = 1'b1;
          w_fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_res0      <= '0;
      r_res1      <= '0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_num0  <= '0;
      r_eng_num1  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_eng_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_pick;
            r_eng_num0  <= w_op_a;
            r_eng_num1  <= w_op_b;
            r_gnt0      <= ~w_pick;
            r_gnt1      <= w_pick;
            r_eng_start <= ~w_op_zero;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!w_fin) begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus._eng_done) r_cnt <= w_cnt_next;
        end
        S_RESPOND: begin
          r_last     <= r_owner;
          r_cnt      <= '0;
          r_eng_num0 <= '0;
          r_eng_num1 <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_fin) begin
        r_state <= S_RESPOND;
        if (r_owner) begin
          r_done1 <= 1'b1;
          r_res1  <= w_fin_res;
          r_err1  <= w_fin_err;
        end else begin
          r_done0 <= 1'b1;
          r_res0  <= w_fin_res;
          r_err0  <= w_fin_err;
        end
      end
    end
  end

  assign bus._gnt0      = r_gnt0;
  assign bus._gnt1      = r_gnt1;
  assign bus._done0     = r_done0;
  assign bus._done1     = r_done1;
  assign bus._res0      = r_res0;
  assign bus._res1      = r_res1;
  assign bus._err0      = r_err0;
  assign bus._err1      = r_err1;
  assign bus._eng_start = r_eng_start;
  assign bus._eng_num0  = r_eng_num0;
  assign bus._eng_num1  = r_eng_num1;
  assign bus._busy      = r_busy;
  assign o_dbg_state    = r_state;

endmodule
